// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel write master: default widths, FIFO depth,
// accept-FSM state encoding and the packed pixel request.
// Imported by pixel_fifo, pixel_write_master and their benches.
package pixel_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    ACCEPT = 1'b0,
    ACK    = 1'b1
  } acc_state_e;

  // One buffered pixel at the default widths: byte address plus RGB565 colour.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] color;
  } pix_req_t;

endpackage

// File: rtl/pixel_fifo.sv
// Purpose: synchronous FIFO holding packed {address, colour} pixel requests.
// Latency: a push is visible on head_o/count_o the cycle after it is taken.
// Backpressure: full_o/empty_o come from the registered count; a push while
//   full or a pop while empty is ignored (no bypass when full).
// Ports: clk_i/reset_i (sync, active-high), push_i/data_i, pop_i,
//   full_o, empty_o, count_o, head_o.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_WIDTH + DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are exactly PTR_W bits wide so they wrap modulo DEPTH for free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads a slot before it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_write_master.sv
// Purpose: captures Draw/Pixel_Address/Color requests into a FIFO, acks each
//   with a one-cycle Write_Finish, and drains them as Avalon-MM single writes.
// Latency: Write_Finish one cycle after capture; master_write asserts the
//   cycle after a push into an empty FIFO.
// Backpressure: master_waitrequest stalls the head write; when the FIFO is
//   full Draw is simply not captured and no acknowledge is given.
// Ports: clk, reset (sync, active-high); Draw, Pixel_Address, Color,
//   Write_Finish, Idle (line-engine side); master_* (Avalon-MM master).
module pixel_write_master
  import pixel_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Draw,
  input  logic [ADDR_WIDTH-1:0]   Pixel_Address,
  input  logic [DATA_WIDTH-1:0]   Color,
  output logic                    Write_Finish,
  output logic                    Idle,
  output logic [ADDR_WIDTH-1:0]   master_address,
  output logic                    master_write,
  output logic [DATA_WIDTH-1:0]   master_writedata,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  input  logic                    master_waitrequest
);

  localparam int REQ_W = ADDR_WIDTH + DATA_WIDTH;

  acc_state_e                  state_q, state_d;
  logic                        push, pop;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [REQ_W-1:0]            fifo_head;

  // Accept FSM: one capture per ACCEPT->ACK round trip, so at most one pixel
  // every two cycles; the ack never waits on the memory side.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ACCEPT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ACCEPT: begin
        // Full is taken from the registered count: a same-cycle pop does
        // not open a slot for this request.
        if (Draw && !fifo_full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  pixel_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  ({Pixel_Address, Color}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign Write_Finish = (state_q == ACK);
  assign Idle         = (fifo_count == '0) && (state_q == ACCEPT);

  // Outputs are pure functions of registered FIFO state, so they hold still
  // for as long as waitrequest stalls the head entry.
  assign master_write      = (fifo_count != '0);
  assign pop               = master_write && !master_waitrequest;
  assign master_address    = fifo_empty ? '0 : fifo_head[REQ_W-1:DATA_WIDTH];
  assign master_writedata  = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign master_byteenable = '1;

endmodule

// File: tb/tb_pixel_write_master.sv
module tb_pixel_write_master;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Draw;
  logic [31:0] Pixel_Address;
  logic [15:0] Color;
  logic        Write_Finish;
  logic        Idle;
  logic [31:0] master_address;
  logic        master_write;
  logic [15:0] master_writedata;
  logic [1:0]  master_byteenable;
  logic        master_waitrequest;

  pixel_write_master dut (
    .clk                (clk),
    .reset              (reset),
    .Draw               (Draw),
    .Pixel_Address      (Pixel_Address),
    .Color              (Color),
    .Write_Finish       (Write_Finish),
    .Idle               (Idle),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_byteenable  (master_byteenable),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pix_req_t exp_q[$];
  int       ack_cyc[$];
  int       wr_cyc[$];
  int       wr_cnt = 0;
  int       idle_cnt = 0;

  // waitrequest source: 0 = fixed level, 1 = high only in ACK cycles,
  // 2 = random 50%.
  int   wr_mode = 0;
  logic wr_fixed = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #2;
    case (wr_mode)
      0:       master_waitrequest = wr_fixed;
      1:       master_waitrequest = Write_Finish;
      default: master_waitrequest = 1'($urandom_range(0, 1));
    endcase
  end

  logic        prv_vld = 1'b0;
  logic        prv_reset, prv_write, prv_wait;
  logic [31:0] prv_addr;
  logic [15:0] prv_data;

  // Output monitor: scoreboard pop on each accepted write, Avalon stability.
  always @(negedge clk) begin
    pix_req_t e;
    if (Write_Finish === 1'b1) ack_cyc.push_back(cyc);
    if (Idle === 1'b1) idle_cnt++;
    if (reset === 1'b0 && master_write === 1'b1 && master_waitrequest === 1'b0) begin
      wr_cyc.push_back(cyc);
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stale_write: got addr=%h data=%h, expected no write", master_address, master_writedata);
      end else begin
        e = exp_q.pop_front();
        if (master_address !== e.addr || master_writedata !== e.color) begin
          errors++;
          $display("FAIL write_order: got addr=%h data=%h, expected addr=%h data=%h",
                   master_address, master_writedata, e.addr, e.color);
        end
      end
    end
    if (prv_vld && prv_reset === 1'b0 && prv_write === 1'b1 && prv_wait === 1'b1) begin
      checks++;
      if (master_write !== 1'b1 || master_address !== prv_addr ||
          master_writedata !== prv_data || master_byteenable !== 2'b11) begin
        errors++;
        $display("FAIL avalon_stable: got w=%b a=%h d=%h be=%b, expected w=1 a=%h d=%h be=11",
                 master_write, master_address, master_writedata, master_byteenable, prv_addr, prv_data);
      end
    end
    prv_vld   = 1'b1;
    prv_reset = reset;
    prv_write = master_write;
    prv_wait  = master_waitrequest;
    prv_addr  = master_address;
    prv_data  = master_writedata;
  end

  // Present one request and hold it until Write_Finish; returns at posedge+1
  // of the cycle after the ack, ready for the next request.
  task automatic send(input logic [31:0] a, input logic [15:0] c, input int budget);
    pix_req_t r;
    bit got;
    Draw = 1'b1;
    Pixel_Address = a;
    Color = c;
    r.addr = a;
    r.color = c;
    exp_q.push_back(r);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (Write_Finish === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: addr=%h got no Write_Finish, expected one within %0d cycles", a, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && Idle === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding Idle=%b, expected 0 and Idle=1", name, exp_q.size(), Idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Draw = 1'b0;
    Pixel_Address = '0;
    Color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (Write_Finish !== 1'b0) begin errors++; $display("FAIL rst_wf: got %b expected 0", Write_Finish); end
    if (master_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", master_write); end
    if (Idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", Idle); end
    if (master_address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", master_address); end
    if (master_writedata !== 16'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", master_writedata); end
    if (master_byteenable !== 2'b11) begin errors++; $display("FAIL rst_be: got %b expected 11", master_byteenable); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int n0;
    wr_mode = 0;
    wr_fixed = 1'b0;
    ack_cyc.delete();
    n0 = wr_cnt;
    Draw = 1'b1;
    Pixel_Address = 32'h0800_0400;
    Color = 16'hF800;
    exp_q.push_back('{addr: 32'h0800_0400, color: 16'hF800});
    @(negedge clk);
    checks += 2;
    if (Write_Finish !== 1'b0) begin errors++; $display("FAIL single_wf_c0: got %b expected 0", Write_Finish); end
    if (master_write !== 1'b0) begin errors++; $display("FAIL single_write_c0: got %b expected 0", master_write); end
    @(negedge clk);
    checks += 4;
    if (Write_Finish !== 1'b1) begin errors++; $display("FAIL single_wf_c1: got %b expected 1", Write_Finish); end
    if (master_write !== 1'b1) begin errors++; $display("FAIL single_write_c1: got %b expected 1", master_write); end
    if (master_address !== 32'h0800_0400) begin errors++; $display("FAIL single_addr: got %h expected 08000400", master_address); end
    if (master_writedata !== 16'hF800) begin errors++; $display("FAIL single_data: got %h expected f800", master_writedata); end
    @(posedge clk);
    #1;
    Draw = 1'b0;
    @(negedge clk);
    checks += 3;
    if (Write_Finish !== 1'b0) begin errors++; $display("FAIL single_wf_c2: got %b expected 0", Write_Finish); end
    if (master_write !== 1'b0) begin errors++; $display("FAIL single_write_c2: got %b expected 0", master_write); end
    if (Idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", Idle); end
    repeat (4) @(negedge clk);
    checks += 2;
    if (wr_cnt - n0 != 1) begin errors++; $display("FAIL single_nwrites: got %0d expected 1", wr_cnt - n0); end
    if (ack_cyc.size() != 1) begin errors++; $display("FAIL single_nacks: got %0d expected 1", ack_cyc.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_pressure();
    wr_mode = 0;
    wr_fixed = 1'b1;
    ack_cyc.delete();
    wr_cyc.delete();
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'h10 + 32'(2 * i), 16'h1000 + 16'(i), 200);
        Draw = 1'b0;
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        checks += 3;
        if (ack_cyc.size() != 4) begin errors++; $display("FAIL bp_stall_acks: got %0d expected 4", ack_cyc.size()); end
        if (master_address !== 32'h10) begin errors++; $display("FAIL bp_head_addr: got %h expected 10", master_address); end
        if (master_write !== 1'b1) begin errors++; $display("FAIL bp_head_write: got %b expected 1", master_write); end
        for (int i = 1; i < 4 && i < ack_cyc.size(); i++) begin
          checks++;
          if (ack_cyc[i] - ack_cyc[i-1] != 2) begin
            errors++;
            $display("FAIL bp_ack_spacing: ack %0d gap %0d expected 2", i, ack_cyc[i] - ack_cyc[i-1]);
          end
        end
        wr_fixed = 1'b0;
      end
    join
    drain("bp");
    checks += 2;
    if (ack_cyc.size() != 5) begin errors++; $display("FAIL bp_total_acks: got %0d expected 5", ack_cyc.size()); end
    if (wr_cyc.size() != 5) begin errors++; $display("FAIL bp_total_writes: got %0d expected 5", wr_cyc.size()); end
    if (wr_cyc.size() == 5 && ack_cyc.size() == 5) begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != 1) begin
          errors++;
          $display("FAIL bp_b2b_write: write %0d gap %0d expected 1", i, wr_cyc[i] - wr_cyc[i-1]);
        end
      end
      checks++;
      if (ack_cyc[4] <= wr_cyc[0]) begin
        errors++;
        $display("FAIL bp_fifth_ack: got ack cycle %0d expected after first write %0d", ack_cyc[4], wr_cyc[0]);
      end
    end
  endtask

  task automatic test_push_pop();
    int n0, idle_snap;
    wr_mode = 1;
    n0 = wr_cnt;
    send(32'h100, 16'h0A00, 50);
    idle_cnt = 0;
    for (int i = 1; i < 12; i++) send(32'h100 + 32'(2 * i), 16'h0A00 + 16'(i), 50);
    idle_snap = idle_cnt;
    Draw = 1'b0;
    wr_mode = 0;
    wr_fixed = 1'b0;
    drain("pushpop");
    checks += 2;
    if (idle_snap != 0) begin errors++; $display("FAIL pushpop_count1: Idle seen %0d cycles, expected 0", idle_snap); end
    if (wr_cnt - n0 != 12) begin errors++; $display("FAIL pushpop_nwrites: got %0d expected 12", wr_cnt - n0); end
  endtask

  task automatic test_wrap();
    int n0;
    wr_mode = 2;
    n0 = wr_cnt;
    for (int i = 0; i < 9; i++) send(32'h200 + 32'(2 * i), 16'($urandom()), 100);
    Draw = 1'b0;
    drain("wrap");
    wr_mode = 0;
    wr_fixed = 1'b0;
    checks++;
    if (wr_cnt - n0 != 9) begin errors++; $display("FAIL wrap_nwrites: got %0d expected 9", wr_cnt - n0); end
  endtask

  task automatic test_reset_mid();
    int n0;
    wr_mode = 0;
    wr_fixed = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h300 + 32'(2 * i), 16'h5500 + 16'(i), 50);
    // A fourth request arrives in the reset cycle and must not be acknowledged.
    Draw = 1'b1;
    Pixel_Address = 32'h306;
    Color = 16'h5503;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    Draw = 1'b0;
    wr_fixed = 1'b0;
    n0 = wr_cnt;
    @(negedge clk);
    checks += 4;
    if (master_write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b expected 0", master_write); end
    if (Write_Finish !== 1'b0) begin errors++; $display("FAIL rstmid_wf: got %b expected 0", Write_Finish); end
    if (Idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", Idle); end
    if (master_address !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", master_address); end
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != n0) begin errors++; $display("FAIL rstmid_stale: got %0d writes expected 0", wr_cnt - n0); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    master_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_push_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
